// File: rtl/plab5_mcore_debug_arbiter.sv
// Round-robin arbiter sharing one debug interface between a secure (port 0)
// and a non-secure (port 1) debugger, one transaction at a time.
module plab5_mcore_debug_arbiter #(
    parameter int p_addr_nbits = 32,
    parameter int p_data_nbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0_val,
    output logic                    req0_rdy,
    input  logic [p_addr_nbits-1:0] req0_src_addr,
    input  logic [p_addr_nbits-1:0] req0_dest_addr,
    input  logic                    req0_domain,
    input  logic                    req1_val,
    output logic                    req1_rdy,
    input  logic [p_addr_nbits-1:0] req1_src_addr,
    input  logic [p_addr_nbits-1:0] req1_dest_addr,
    input  logic                    req1_domain,
    output logic                    resp0_val,
    input  logic                    resp0_rdy,
    output logic                    resp1_val,
    input  logic                    resp1_rdy,
    output logic [p_data_nbits-1:0] resp_data,
    output logic                    resp_err,
    output logic                    db_val,
    output logic [p_addr_nbits-1:0] db_src_addr,
    output logic [p_addr_nbits-1:0] db_dest_addr,
    output logic                    db_domain,
    input  logic                    db_result_rdy,
    input  logic [p_data_nbits-1:0] db_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    prio_r;
    logic                    grant_r;
    logic [p_addr_nbits-1:0] src_r;
    logic [p_addr_nbits-1:0] dest_r;
    logic                    domain_r;
    logic [p_data_nbits-1:0] data_r;
    logic                    err_r;
    logic                    db_val_r;
    logic                    resp0_val_r;
    logic                    resp1_val_r;

    logic                    grant_s;
    logic                    fire_s;
    logic                    refuse_s;
    logic                    resp_take_s;

    // Arbitration winner, fire condition and response handshake decode
    always_comb begin
        grant_s = 1'b0;
        if (req0_val && req1_val) begin
            grant_s = prio_r;
        end else if (req1_val) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        fire_s      = (state_r == IDLE) && (req0_val || req1_val);
        refuse_s    = grant_s && req1_domain;
        resp_take_s = grant_r ? resp1_rdy : resp0_rdy;
    end

    // Gating with reset keeps the ready outputs low while reset is asserted
    assign req0_rdy = reset & fire_s & ~grant_s;
    assign req1_rdy = reset & fire_s &  grant_s;

    assign db_val       = db_val_r;
    assign db_src_addr  = src_r;
    assign db_dest_addr = dest_r;
    assign db_domain    = domain_r;
    assign resp0_val    = resp0_val_r;
    assign resp1_val    = resp1_val_r;
    assign resp_data    = data_r;
    assign resp_err     = err_r;

    // Transaction sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            prio_r      <= 1'b0;
            grant_r     <= 1'b0;
            src_r       <= {p_addr_nbits{1'b0}};
            dest_r      <= {p_addr_nbits{1'b0}};
            domain_r    <= 1'b0;
            data_r      <= {p_data_nbits{1'b0}};
            err_r       <= 1'b0;
            db_val_r    <= 1'b0;
            resp0_val_r <= 1'b0;
            resp1_val_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (fire_s) begin
                        src_r    <= grant_s ? req1_src_addr  : req0_src_addr;
                        dest_r   <= grant_s ? req1_dest_addr : req0_dest_addr;
                        domain_r <= grant_s ? req1_domain    : req0_domain;
                        grant_r  <= grant_s;
                        prio_r   <= ~grant_s;
                        // Non-secure port asking for the secure domain never reaches the debug interface
                        if (refuse_s) begin
                            err_r       <= 1'b1;
                            data_r      <= {p_data_nbits{1'b0}};
                            resp1_val_r <= 1'b1;
                            state_r     <= RESP;
                        end else begin
                            db_val_r <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    db_val_r <= 1'b0;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    if (db_result_rdy) begin
                        data_r      <= db_result;
                        err_r       <= 1'b0;
                        resp0_val_r <= ~grant_r;
                        resp1_val_r <=  grant_r;
                        state_r     <= RESP;
                    end
                end
                RESP: begin
                    if (resp_take_s) begin
                        resp0_val_r <= 1'b0;
                        resp1_val_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    db_val_r    <= 1'b0;
                    resp0_val_r <= 1'b0;
                    resp1_val_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plab5_mcore_debug_arbiter.sv
// Randomized transaction-level bench for plab5_mcore_debug_arbiter; expectations come
// from a round-robin pointer and per-transaction timing rules kept in the bench.
module tb_plab5_mcore_debug_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_val, req1_val, req0_rdy, req1_rdy;
    logic [31:0] req0_src_addr, req0_dest_addr, req1_src_addr, req1_dest_addr;
    logic        req0_domain, req1_domain;
    logic        resp0_val, resp1_val, resp0_rdy, resp1_rdy;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        db_val;
    logic [31:0] db_src_addr, db_dest_addr;
    logic        db_domain;
    logic        db_result_rdy;
    logic [31:0] db_result;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_prio  = 1'b0;

    always #5 clk = ~clk;

    plab5_mcore_debug_arbiter #(.p_addr_nbits(32), .p_data_nbits(32)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_src_addr(req0_src_addr),
        .req0_dest_addr(req0_dest_addr), .req0_domain(req0_domain),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_src_addr(req1_src_addr),
        .req1_dest_addr(req1_dest_addr), .req1_domain(req1_domain),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .resp_data(resp_data), .resp_err(resp_err),
        .db_val(db_val), .db_src_addr(db_src_addr), .db_dest_addr(db_dest_addr),
        .db_domain(db_domain), .db_result_rdy(db_result_rdy), .db_result(db_result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_db_val"}, db_val, 0);
        check({tag, "_db_src"}, db_src_addr, 0);
        check({tag, "_db_dest"}, db_dest_addr, 0);
        check({tag, "_db_dom"}, db_domain, 0);
        check({tag, "_resp_val"}, {resp0_val, resp1_val}, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_req_rdy"}, {req0_rdy, req1_rdy}, 0);
    endtask

    // One full transaction, starting at a negedge with the arbiter idle.
    task automatic txn(input bit v0, input bit v1, input bit dm0, input bit dm1,
                       input logic [31:0] s0, input logic [31:0] t0,
                       input logic [31:0] s1, input logic [31:0] t1,
                       input int lat, input int bp, input logic [31:0] res);
        bit          g, refused, exp_dom, exp_err;
        logic [31:0] exp_src, exp_dst, exp_data;
        req0_val = v0; req1_val = v1;
        req0_src_addr = s0; req0_dest_addr = t0; req0_domain = dm0;
        req1_src_addr = s1; req1_dest_addr = t1; req1_domain = dm1;
        #1;
        g = (v0 && v1) ? m_prio : v1;
        check("req0_rdy", req0_rdy, 64'(v0 && !g));
        check("req1_rdy", req1_rdy, 64'(v1 && g));
        refused = g && dm1;
        exp_src = g ? s1 : s0;
        exp_dst = g ? t1 : t0;
        exp_dom = g ? dm1 : dm0;
        m_prio  = !g;
        @(negedge clk);
        req0_val = 1'b0; req1_val = 1'b0;
        if (refused) begin
            check("db_val_refused", db_val, 0);
            exp_data = 32'h0;
            exp_err  = 1'b1;
        end else begin
            check("db_val", db_val, 1);
            check("db_src", db_src_addr, exp_src);
            check("db_dest", db_dest_addr, exp_dst);
            check("db_dom", db_domain, exp_dom);
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                check("db_val_wait", db_val, 0);
                check("resp_early", {resp0_val, resp1_val}, 0);
                check("db_src_hold", db_src_addr, exp_src);
            end
            db_result = res; db_result_rdy = 1'b1;
            @(negedge clk);
            db_result_rdy = 1'b0; db_result = $urandom;
            exp_data = res;
            exp_err  = 1'b0;
        end
        check("resp0_val", resp0_val, 64'(!g));
        check("resp1_val", resp1_val, 64'(g));
        check("resp_data", resp_data, exp_data);
        check("resp_err", resp_err, exp_err);
        for (int i = 0; i < bp; i++) begin
            if (g) begin req0_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b0; end
            else   begin req1_val = 1'b1; resp1_rdy = 1'b1; resp0_rdy = 1'b0; end
            #1;
            check("other_rdy_bp", {req0_rdy, req1_rdy}, 0);
            @(negedge clk);
            check("resp_val_bp", {resp0_val, resp1_val}, g ? 64'd1 : 64'd2);
            check("resp_data_bp", resp_data, exp_data);
            check("db_val_bp", db_val, 0);
        end
        req0_val = 1'b0; req1_val = 1'b0;
        resp0_rdy = !g; resp1_rdy = g;
        @(negedge clk);
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        check("resp_done", {resp0_val, resp1_val}, 0);
        check("db_val_done", db_val, 0);
    endtask

    initial begin
        reset = 1'b0;
        req0_val = 1'b0; req1_val = 1'b0;
        req0_src_addr = 32'h0; req0_dest_addr = 32'h0; req0_domain = 1'b0;
        req1_src_addr = 32'h0; req1_dest_addr = 32'h0; req1_domain = 1'b0;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        db_result_rdy = 1'b0; db_result = 32'h0;
        @(negedge clk); @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        m_prio = 1'b0;

        // Simultaneous requests: 0, then 1, then 0 again
        txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 3, 0, $urandom);
        txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 2, 0, $urandom);
        txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 1, 0, $urandom);

        // Single port 0 request with secure domain
        txn(1, 0, 1, 0, 32'h100, 32'h200, $urandom, $urandom, 6, 0, 32'hCAFE);

        // Refused non-secure request for the secure domain
        txn(0, 1, 0, 1, $urandom, $urandom, $urandom, $urandom, 2, 0, $urandom);

        // Response backpressure on port 0
        txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, 2, 5, $urandom);

        // Spurious db_result_rdy while idle
        db_result = 32'hDEAD_BEEF; db_result_rdy = 1'b1;
        @(negedge clk);
        db_result_rdy = 1'b0;
        check("spurious_resp", {resp0_val, resp1_val}, 0);
        check("spurious_db_val", db_val, 0);
        @(negedge clk);
        check("spurious_resp2", {resp0_val, resp1_val}, 0);
        txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 1, 0, $urandom);

        // Reset mid-WAIT
        req0_val = 1'b1; req0_src_addr = 32'h55; req0_dest_addr = 32'h66; req0_domain = 1'b1;
        @(negedge clk);
        req0_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        req0_val = 1'b1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_wait");
        req0_val = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_prio = 1'b0;
        txn(1, 0, 0, 0, $urandom, $urandom, $urandom, $urandom, 4, 1, 32'h1234_5678);
        txn(1, 1, 0, 0, $urandom, $urandom, $urandom, $urandom, 1, 0, $urandom);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            bit rv0, rv1;
            rv0 = 1'($urandom_range(0, 1));
            rv1 = 1'($urandom_range(0, 1));
            if (!rv0 && !rv1) rv0 = 1'b1;
            txn(rv0, rv1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom,
                $urandom_range(1, 8), $urandom_range(0, 4), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
